fifo_write: RTL

- Upstream producer stage for the byte-FIFO read block: takes a FIFO_NUM-byte flat word and pushes it into the byte FIFO one byte per cycle.
- Uses the same fs/fd start/done handshake as the read side, so a controller can chain write→read.
- Honours FIFO full back-pressure and aborts cleanly on err.

---
 rtl/fifo_pkg.sv | 11 +
 rtl/fifo_write.sv | 82 ++++++++
 2 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FSM states and widths for the byte-FIFO write and read blocks
package fifo_pkg;
    localparam int BYTE_W = 8;
    localparam int CNT_W  = 12;
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        LOAD = 3'd1,
        WORK = 3'd2,
        LAST = 3'd3
    } state_t;
endpackage

// File: rtl/fifo_write.sv
// fifo_write: pushes a FIFO_NUM-byte word into a byte FIFO, one byte per cycle, MSB byte first
// Ports: clk, rst (async, active-high), err (sync abort), data (payload, byte 0 = MSB byte),
//        fs (start level), fd (done, high in LAST), fifo_full (back-pressure),
//        fifo_txen (FIFO write enable), dout (FIFO write data).
// Build option FIFO_WRITE_CSUM_EN: appends a mod-256 sum of the data bytes as one extra write.
module fifo_write
    import fifo_pkg::*;
#(
    parameter logic [CNT_W-1:0] FIFO_NUM = 12'd8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       err,
    input  logic [FIFO_NUM*BYTE_W-1:0] data,
    input  logic                       fs,
    output logic                       fd,
    input  logic                       fifo_full,
    output logic                       fifo_txen,
    output logic [BYTE_W-1:0]          dout
);
    localparam int DW = FIFO_NUM * BYTE_W;
`ifdef FIFO_WRITE_CSUM_EN
    localparam logic [CNT_W-1:0] LAST_CNT = FIFO_NUM;
`else
    localparam logic [CNT_W-1:0] LAST_CNT = FIFO_NUM - 12'd1;
`endif

    state_t              state, state_n;
    logic [CNT_W-1:0]    cnt;
    logic [DW-1:0]       shadow, shifted;
    logic [BYTE_W-1:0]   data_byte;
    logic                last_wr;

    // shifting the word left by cnt bytes brings byte[cnt] to the top
    assign shifted   = shadow << {cnt, 3'b000};
    assign data_byte = shifted[DW-1 -: BYTE_W];
    assign fifo_txen = (state == WORK) && !fifo_full;
    assign last_wr   = fifo_txen && (cnt == LAST_CNT);
    assign fd        = (state == LAST);

`ifdef FIFO_WRITE_CSUM_EN
    logic [BYTE_W-1:0] csum;
    assign dout = (state == WORK) ? ((cnt == FIFO_NUM) ? csum : data_byte) : '0;
    always_ff @(posedge clk or posedge rst)
        if (rst)
            csum <= '0;
        else if (state == LOAD)
            csum <= '0;
        else if (fifo_txen && cnt != FIFO_NUM)
            csum <= csum + data_byte;
`else
    assign dout = (state == WORK) ? data_byte : '0;
`endif

    always_comb begin
        state_n = IDLE;
        case (state)
            IDLE:    state_n = fs ? LOAD : IDLE;
            LOAD:    state_n = WORK;
            WORK:    state_n = last_wr ? LAST : WORK;
            LAST:    state_n = fs ? LAST : IDLE;
            default: state_n = IDLE;
        endcase
        if (err)
            state_n = IDLE;
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            shadow <= '0;
        end else begin
            state <= state_n;
            if (err || state == LOAD)
                cnt <= '0;
            else if (fifo_txen && !last_wr)
                cnt <= cnt + 12'd1;
            if (state == LOAD)
                shadow <= data;
        end
endmodule
